// File: rtl/regfile_pkg.sv
// Shared helpers for the multi-port register file: address-width sizing,
// the zero-entry index, the reset value and packed-bus field extraction.
package regfile_pkg;

    localparam int ZERO_IDX = 0;

    // Reset value wide enough for any practical WIDTH; consumers take the low bits
    localparam int RF_MAX_WIDTH = 1024;
    localparam logic [RF_MAX_WIDTH-1:0] RF_RESET_VAL = '0;

    function automatic int calc_aw(input int depth);
        int aw;
        aw = $clog2(depth);
        return (aw < 1) ? 1 : aw;
    endfunction

    function automatic logic [7:0] port_field(input logic [31:0] vec, input int p, input int aw);
        logic [31:0] w_sh;
        w_sh = vec >> (p * aw);
        return w_sh[7:0] & ~(8'hFF << aw);
    endfunction

endpackage

// File: rtl/register_n.sv
// Enable flop of arbitrary width with asynchronous active-low clear.
module register_n
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clock,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Storage: cleared by reset, loaded when enabled
    always_ff @(posedge i_clock or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= RF_RESET_VAL[WIDTH-1:0];
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: one write port, NUM_READ read ports, optional
// hardwired-zero entry 0, write-to-read bypass and registered read outputs.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NUM_READ = 2,
    parameter int BYPASS   = 1,
    parameter int REG_OUT  = 0,
    parameter int ZERO_REG = 1,
    localparam int AW      = calc_aw(DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      write_enable,
    input  logic [AW-1:0]             write_addr,
    input  logic [WIDTH-1:0]          write_data,
    input  logic [NUM_READ*AW-1:0]    read_addr,
    output logic [NUM_READ*WIDTH-1:0] read_data
);

    localparam int AWP = AW + 1;
    localparam logic [AW:0] DEPTH_V = AWP'(DEPTH);

    logic [31:0]      w_ra_bus;
    logic             w_wr_in_range;
    logic             w_wr_zero;
    logic             w_commit;
    logic [DEPTH-1:0] w_wen;
    logic [WIDTH-1:0] w_mem [DEPTH];

    assign w_ra_bus = 32'(read_addr);

    // A write commits only in range, off the zero entry, and never while in reset
    always_comb begin
        w_wr_in_range = ({1'b0, write_addr} < DEPTH_V);
        w_wr_zero     = (ZERO_REG != 0) && (write_addr == AW'(ZERO_IDX));
        w_commit      = write_enable && reset_n && w_wr_in_range && !w_wr_zero;
    end

    // One-hot write enable per entry
    always_comb begin
        w_wen = '0;
        for (int e = 0; e < DEPTH; e++) begin
            w_wen[e] = w_commit && (write_addr == AW'(e));
        end
    end

    for (genvar e = 0; e < DEPTH; e++) begin : g_entry
        register_n #(.WIDTH(WIDTH)) u_entry (
            .i_clock (clock),
            .i_rst_n (reset_n),
            .i_en    (w_wen[e]),
            .i_d     (write_data),
            .o_q     (w_mem[e])
        );
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_read
        logic [AW-1:0]    w_ra;
        logic             w_in_range;
        logic [WIDTH-1:0] w_entry;
        logic [WIDTH-1:0] w_val;

        assign w_ra = AW'(port_field(w_ra_bus, p, AW));

        // AND-OR mux: unmatched high codes select nothing, so storage is never over-indexed
        always_comb begin
            w_in_range = ({1'b0, w_ra} < DEPTH_V);
            w_entry    = '0;
            for (int e = 0; e < DEPTH; e++) begin
                w_entry = w_entry | (w_mem[e] & {WIDTH{w_ra == AW'(e)}});
            end
            if ((ZERO_REG != 0) && (w_ra == AW'(ZERO_IDX))) begin
                w_val = '0;
            end else if (!w_in_range) begin
                w_val = '0;
            end else if ((BYPASS != 0) && w_commit && (w_ra == write_addr)) begin
                w_val = write_data;
            end else begin
                w_val = w_entry;
            end
        end

        if (REG_OUT != 0) begin : g_reg
            register_n #(.WIDTH(WIDTH)) u_out (
                .i_clock (clock),
                .i_rst_n (reset_n),
                .i_en    (1'b1),
                .i_d     (w_val),
                .o_q     (read_data[p*WIDTH +: WIDTH])
            );
        end else begin : g_comb
            assign read_data[p*WIDTH +: WIDTH] = w_val;
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: four register-file builds share one stimulus stream and
// are compared against a per-build reference model through a scoreboard queue.
module tb_regfile_mp;

    logic        clock;
    logic        reset_n;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [19:0] read_addr;
    logic [127:0] rd_all [4];

    // Build table: A, B, C, D
    localparam int DEP  [4] = '{32, 24, 32, 24};
    localparam int BYP  [4] = '{1, 0, 0, 1};
    localparam int REGO [4] = '{0, 1, 0, 1};
    localparam int ZR   [4] = '{1, 0, 0, 1};

    typedef struct {
        int           c;
        logic [127:0] v;
    } exp_t;

    exp_t         sb_q [$];
    logic [31:0]  mem [4][32];
    logic [127:0] last_reg [4];
    int checks = 0;
    int errors = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_READ(4), .BYPASS(1), .REG_OUT(0), .ZERO_REG(1)) u_dut_a (
        .clock(clock), .reset_n(reset_n), .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .read_addr(read_addr), .read_data(rd_all[0]));
    regfile_mp #(.WIDTH(32), .DEPTH(24), .NUM_READ(4), .BYPASS(0), .REG_OUT(1), .ZERO_REG(0)) u_dut_b (
        .clock(clock), .reset_n(reset_n), .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .read_addr(read_addr), .read_data(rd_all[1]));
    regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_READ(4), .BYPASS(0), .REG_OUT(0), .ZERO_REG(0)) u_dut_c (
        .clock(clock), .reset_n(reset_n), .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .read_addr(read_addr), .read_data(rd_all[2]));
    regfile_mp #(.WIDTH(32), .DEPTH(24), .NUM_READ(4), .BYPASS(1), .REG_OUT(1), .ZERO_REG(1)) u_dut_d (
        .clock(clock), .reset_n(reset_n), .write_enable(write_enable), .write_addr(write_addr),
        .write_data(write_data), .read_addr(read_addr), .read_data(rd_all[3]));

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic commit_ok(input int c);
        return write_enable && reset_n && (int'(write_addr) < DEP[c])
               && !((ZR[c] != 0) && (write_addr == 5'd0));
    endfunction

    function automatic logic [31:0] model_v(input int c, input logic [4:0] a);
        if ((ZR[c] != 0) && (a == 5'd0)) return 32'd0;
        else if (int'(a) >= DEP[c]) return 32'd0;
        else if ((BYP[c] != 0) && commit_ok(c) && (a == write_addr)) return write_data;
        else return mem[c][a];
    endfunction

    function automatic logic [127:0] model_vec(input int c);
        logic [127:0] v;
        v = '0;
        for (int p = 0; p < 4; p++) v[p*32 +: 32] = model_v(c, read_addr[p*5 +: 5]);
        return v;
    endfunction

    task automatic model_commit();
        for (int c = 0; c < 4; c++) begin
            if (commit_ok(c)) mem[c][write_addr] = write_data;
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 32; i++) mem[c][i] = 32'd0;
            last_reg[c] = 128'd0;
        end
        sb_q.delete();
    endtask

    task automatic cmp_vec(input string tag, input int c, input logic [127:0] exp);
        for (int p = 0; p < 4; p++) begin
            check_val($sformatf("%s c%0d p%0d", tag, c, p), rd_all[c][p*32 +: 32], exp[p*32 +: 32]);
        end
    endtask

    // One cycle, entered and left at a falling edge
    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic [19:0] ra);
        exp_t e;
        write_enable = we;
        write_addr   = wa;
        write_data   = wd;
        read_addr    = ra;
        #1;
        for (int c = 0; c < 4; c++) begin
            if (REGO[c] == 0) begin
                cmp_vec("comb", c, model_vec(c));
            end else begin
                cmp_vec("hold", c, last_reg[c]);
                e.c = c;
                e.v = model_vec(c);
                sb_q.push_back(e);
            end
        end
        @(posedge clock);
        model_commit();
        @(negedge clock);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp_vec("reg", e.c, e.v);
            last_reg[e.c] = e.v;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        write_enable = 1'b0;
        write_addr   = 5'd0;
        write_data   = 32'd0;
        read_addr    = 20'd0;
        model_reset();
        #1;
        for (int c = 0; c < 4; c++) cmp_vec("reset", c, 128'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 32; i++) begin
            step(1'b1, 5'(i), 32'(i) * 32'h01010101, {5'(i), 5'(31 - i), 5'(i), 5'd1});
        end

        step(1'b1, 5'd0, 32'h12345678, {4{5'd0}});
        step(1'b0, 5'd0, 32'd0, {4{5'd0}});

        step(1'b1, 5'd7, 32'hA5A5A5A5, {5'd8, 5'd7, 5'd7, 5'd6});
        step(1'b0, 5'd0, 32'd0, {5'd8, 5'd7, 5'd7, 5'd6});

        step(1'b1, 5'd3, 32'h00000011, {4{5'd0}});
        step(1'b0, 5'd0, 32'd0, {4{5'd3}});

        step(1'b1, 5'd30, 32'h000000FF, {5'd30, 5'd30, 5'd24, 5'd23});
        step(1'b0, 5'd0, 32'd0, {5'd30, 5'd30, 5'd24, 5'd23});

        step(1'b1, 5'd5, 32'hDEADBEEF, {4{5'd5}});
        step(1'b0, 5'd0, 32'd0, {4{5'd5}});
        #2;
        reset_n = 1'b0;
        #1;
        for (int c = 0; c < 4; c++) cmp_vec("rst_async", c, 128'd0);
        model_reset();
        write_enable = 1'b1;
        write_addr   = 5'd5;
        write_data   = 32'hCAFEF00D;
        #1;
        for (int c = 0; c < 4; c++) cmp_vec("rst_nobyp", c, 128'd0);
        @(posedge clock);
        #1;
        for (int c = 0; c < 4; c++) cmp_vec("rst_edge", c, 128'd0);
        @(negedge clock);
        write_enable = 1'b0;
        reset_n      = 1'b1;
        step(1'b0, 5'd0, 32'd0, {4{5'd5}});

        for (int i = 0; i < 32; i++) begin
            step(1'b1, 5'(i), 32'(i) * 32'h01010101, {4{5'd0}});
        end

        for (int n = 0; n < 1000; n++) begin
            logic [4:0]  a;
            logic [19:0] r;
            a = 5'($urandom_range(0, 31));
            r = 20'($urandom);
            if ($urandom_range(0, 3) == 0) r[5 +: 5] = a;
            step(1'($urandom_range(0, 1)), a, $urandom, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
